timer_ctrl_master: RTL and testbench
====================================

Name: timer_ctrl_master

Overview:
- Avalon-MM initiator that programs, starts, services and snapshots a 16-bit-data, 3-bit-address interval-timer slave on the Nios bus side.
- Register map: 0 status (bit0 TO, bit1 RUN; any write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2/3 period L/H, 4/5 snapshot L/H (any write captures the counter).
- Gives local logic a simple command/pulse interface (configure, stop, snapshot, tick) without a CPU.

Parameters:
- POLL_INTERVAL, 64, clocks between status polls while running (min 4).
- RD_LATENCY, 1, fixed clocks from address/chipselect to valid av_readdata (slave registers readdata; no waitrequest).

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- cfg_start  in  1  pulse: load cfg_period, cfg_continuous, cfg_irq_en and start timer
- cfg_period  in  32  period value written to L/H
- cfg_continuous  in  1  CONT bit
- cfg_irq_en  in  1  ITO bit
- cfg_stop  in  1  pulse: stop timer
- snap_req  in  1  pulse: request counter snapshot
- av_address  out  3  slave address
- av_chipselect  out  1  access strobe, one cycle per access
- av_write_n  out  1  0 = write
- av_writedata  out  16  write data
- av_readdata  in  16  read data
- av_irq  in  1  slave irq (used only with TIMER_IRQ_EN)
- busy  out  1  sequence in progress
- running  out  1  last START issued and not stopped/expired
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  16  serviced timeouts, wraps 0xFFFF->0
- snap_value  out  32  captured counter
- snap_valid  out  1  one-cycle pulse when snap_value updated

Behaviour:
- Reset: all outputs 0 except av_write_n=1; state IDLE; poll counter 0.
- Every bus access: one cycle, chipselect=1 with address/write_n/writedata registered; next cycle chipselect=0. Reads sample av_readdata RD_LATENCY cycles after the access cycle.
- States: IDLE, CFG_STOP(wr 1,0x0008), CFG_PL(wr 2,period[15:0]), CFG_PH(wr 3,period[31:16]), CFG_CTL(wr 1,{12'b0,4'b0100|cont<<1|ito}), RUN, POLL_RD(rd 0), POLL_WAIT, CLR(wr 0,0x0000), SNAP_WR(wr 4,0), SNAP_RDL(rd 4)+wait, SNAP_RDH(rd 5)+wait, HALT(wr 1,0x0008).
- cfg_start latched (sticky request) with its config inputs at the pulse; sequence STOP->PL->PH->CTL = 4 accesses, 8 cycles; running=1 after CTL access.
- RUN: poll timer counts to POLL_INTERVAL, then POLL_RD. Read bit0=1 -> CLR, tick pulse on CLR access cycle, tick_count+1. Bit0=0 and bit1=0 with !cont -> running=0 (one-shot expired, TO already serviced).
- One-shot: TO observed -> CLR, tick, running=0, return IDLE.
- Request priority at dispatch points (IDLE/RUN only; never mid-sequence): cfg_stop > cfg_start > snap_req > poll. Requests arriving mid-sequence are held sticky, serviced after current sequence. cfg_stop and cfg_start in same cycle: stop wins, start discarded.
- cfg_stop -> HALT, running=0, IDLE. cfg_stop in IDLE still issues HALT.
- Snapshot: SNAP_WR, SNAP_RDL, SNAP_RDH; snap_value={H,L} updated and snap_valid pulsed in the cycle H is sampled. Allowed in IDLE or RUN; returns to originating state.
- busy=1 in every state except IDLE and RUN.
- Reset mid-sequence: immediate return to reset values; bus idle next cycle (no partial access completed).

Optional Feature:
- TIMER_IRQ_EN defined: RUN does not poll; av_irq (synchronised by one flop) triggers POLL_RD; if cfg_irq_en=0, falls back to polling. Not defined: av_irq ignored, polling only; port remains.

Decomposition:
- Package timer_ctrl_pkg: register address constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5), control bit constants (ITO, CONT, START, STOP), state enum.
- One sub-module natural: timer_ctrl_bus_if (single-access engine: issue one read/write, count RD_LATENCY, return done + data).

Test Plan:
- cfg_start, period=0x0001_E847, cont=1, ito=0 -> writes (1,0x0008),(2,0xE847),(3,0x0001),(1,0x0006) in order; running=1.
- Continuous run with behavioural slave, period 200 -> ticks each ~200 clocks, each followed by write (0,0x0000); after 3 ticks tick_count=3.
- One-shot (cont=0) -> exactly one tick, running=0, FSM IDLE, no further status reads.
- snap_req in RUN, slave snapshot 0x1234_5678 -> access (4,wr),(4,rd),(5,rd); snap_value=0x12345678, one snap_valid pulse.
- cfg_stop and cfg_start same cycle during CFG_PL -> sequence completes, then HALT (1,0x0008); no new start.
- Reset asserted during SNAP_RDL -> outputs to reset values next edge, chipselect=0, snap_valid never pulses.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: register map, control bits and FSM states shared by
// the interval-timer master and its bus engine.
package timer_ctrl_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    localparam logic [15:0] CTL_STOP_WORD = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_STOP,
        S_CFG_PL,
        S_CFG_PH,
        S_CFG_CTL,
        S_RUN,
        S_POLL_RD,
        S_POLL_WAIT,
        S_CLR,
        S_SNAP_WR,
        S_SNAP_RDL,
        S_SNAP_RDH,
        S_HALT
    } state_t;

    function automatic logic [15:0] ctl_word(input logic cont, input logic ito);
        logic [15:0] w;
        w            = '0;
        w[CTL_START] = 1'b1;
        w[CTL_CONT]  = cont;
        w[CTL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_bus_if.sv
// timer_ctrl_bus_if: single Avalon-MM access engine; one chipselect
// cycle per access, reads complete RD_LATENCY cycles later.
module timer_ctrl_bus_if #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_addr,
    input  logic [15:0] i_wdata,
    output logic        o_done,
    output logic [15:0] o_rdata,
    output logic [2:0]  o_av_address,
    output logic        o_av_chipselect,
    output logic        o_av_write_n,
    output logic [15:0] o_av_writedata,
    input  logic [15:0] i_av_readdata
);

    logic        r_act;
    logic        r_we;
    logic        r_cs;
    logic        r_wn;
    logic [2:0]  r_addr;
    logic [15:0] r_wd;
    logic [7:0]  r_cnt;
    logic        w_done;

    // A request is accepted only while no access is outstanding.
    assign w_done = r_act && (r_we || (r_cnt == 8'(RD_LATENCY)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act  <= 1'b0;
            r_we   <= 1'b0;
            r_cs   <= 1'b0;
            r_wn   <= 1'b1;
            r_addr <= '0;
            r_wd   <= '0;
            r_cnt  <= '0;
        end else begin
            r_cs <= 1'b0;
            r_wn <= 1'b1;
            if (!r_act) begin
                if (i_req) begin
                    r_act  <= 1'b1;
                    r_cs   <= 1'b1;
                    r_wn   <= !i_we;
                    r_we   <= i_we;
                    r_addr <= i_addr;
                    r_wd   <= i_wdata;
                    r_cnt  <= '0;
                end
            end else if (w_done) begin
                r_act <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_done          = w_done;
    assign o_rdata         = i_av_readdata;
    assign o_av_address    = r_addr;
    assign o_av_chipselect = r_cs;
    assign o_av_write_n    = r_wn;
    assign o_av_writedata  = r_wd;

endmodule

// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: programs, polls, services and snapshots an interval
// timer. Define TIMER_IRQ_EN to trigger status reads from av_irq.
module timer_ctrl_master
    import timer_ctrl_pkg::*;
#(
    parameter int POLL_INTERVAL = 64,
    parameter int RD_LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic        cfg_irq_en,
    input  logic        cfg_stop,
    input  logic        snap_req,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        av_irq,
    output logic        busy,
    output logic        running,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid
);

    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_stop_pend;
    logic        r_start_pend;
    logic        r_snap_pend;
    logic [31:0] r_p_period;
    logic        r_p_cont;
    logic        r_p_ito;
    logic [31:0] r_period;
    logic        r_cont;
    logic        r_ito;
    logic        r_ret_run;
    logic [15:0] r_poll_cnt;
    logic        r_running;
    logic [15:0] r_tick_cnt;
    logic [15:0] r_snap_l;
    logic [31:0] r_snap_value;
    logic        r_snap_valid;

    logic        w_take_stop;
    logic        w_take_start;
    logic        w_take_snap;
    logic        w_poll_due;
    logic        w_expired;
    logic        w_req;
    logic        w_we;
    logic [2:0]  w_addr;
    logic [15:0] w_wdata;
    logic        w_done;
    logic [15:0] w_rdata;

`ifdef TIMER_IRQ_EN
    logic r_irq_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq_sync <= 1'b0;
        else          r_irq_sync <= av_irq;
    end

    assign w_poll_due = r_ito ? r_irq_sync : (r_poll_cnt == POLL_LAST);
`else
    logic w_unused_irq;

    assign w_unused_irq = av_irq;
    assign w_poll_due   = (r_poll_cnt == POLL_LAST);
`endif

    assign w_expired = !w_rdata[ST_TO] && !w_rdata[ST_RUN] && !r_cont;

    timer_ctrl_bus_if #(
        .RD_LATENCY(RD_LATENCY)
    ) u_bus (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_req          (w_req),
        .i_we           (w_we),
        .i_addr         (w_addr),
        .i_wdata        (w_wdata),
        .o_done         (w_done),
        .o_rdata        (w_rdata),
        .o_av_address   (av_address),
        .o_av_chipselect(av_chipselect),
        .o_av_write_n   (av_write_n),
        .o_av_writedata (av_writedata),
        .i_av_readdata  (av_readdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_take_stop  = 1'b0;
        w_take_start = 1'b0;
        w_take_snap  = 1'b0;
        unique case (r_state)
            S_IDLE, S_RUN: begin
                if (r_stop_pend) begin
                    w_take_stop = 1'b1;
                    w_next      = S_HALT;
                end else if (r_start_pend) begin
                    w_take_start = 1'b1;
                    w_next       = S_CFG_STOP;
                end else if (r_snap_pend) begin
                    w_take_snap = 1'b1;
                    w_next      = S_SNAP_WR;
                end else if (r_state == S_RUN && w_poll_due) begin
                    w_next = S_POLL_RD;
                end
            end
            S_CFG_STOP:  if (w_done) w_next = S_CFG_PL;
            S_CFG_PL:    if (w_done) w_next = S_CFG_PH;
            S_CFG_PH:    if (w_done) w_next = S_CFG_CTL;
            S_CFG_CTL:   if (w_done) w_next = S_RUN;
            S_POLL_RD:   if (av_chipselect) w_next = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (w_done) begin
                    if (w_rdata[ST_TO]) w_next = S_CLR;
                    else if (w_expired) w_next = S_IDLE;
                    else                w_next = S_RUN;
                end
            end
            S_CLR:       if (w_done) w_next = r_cont ? S_RUN : S_IDLE;
            S_SNAP_WR:   if (w_done) w_next = S_SNAP_RDL;
            S_SNAP_RDL:  if (w_done) w_next = S_SNAP_RDH;
            S_SNAP_RDH:  if (w_done) w_next = r_ret_run ? S_RUN : S_IDLE;
            S_HALT:      if (w_done) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_addr  = REG_STATUS;
        w_wdata = '0;
        unique case (r_state)
            S_CFG_STOP: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = REG_CONTROL;
                w_wdata = CTL_STOP_WORD;
            end
            S_CFG_PL: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = REG_PERIODL;
                w_wdata = r_period[15:0];
            end
            S_CFG_PH: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = REG_PERIODH;
                w_wdata = r_period[31:16];
            end
            S_CFG_CTL: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = REG_CONTROL;
                w_wdata = ctl_word(r_cont, r_ito);
            end
            S_POLL_RD: w_req = 1'b1;
            S_CLR: begin
                w_req = 1'b1;
                w_we  = 1'b1;
            end
            S_SNAP_WR: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_addr = REG_SNAPL;
            end
            S_SNAP_RDL: begin
                w_req  = 1'b1;
                w_addr = REG_SNAPL;
            end
            S_SNAP_RDH: begin
                w_req  = 1'b1;
                w_addr = REG_SNAPH;
            end
            S_HALT: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = REG_CONTROL;
                w_wdata = CTL_STOP_WORD;
            end
            default: w_req = 1'b0;
        endcase
        busy = (r_state != S_IDLE) && (r_state != S_RUN);
        tick = (r_state == S_CLR) && w_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_pend  <= 1'b0;
            r_start_pend <= 1'b0;
            r_snap_pend  <= 1'b0;
            r_p_period   <= '0;
            r_p_cont     <= 1'b0;
            r_p_ito      <= 1'b0;
            r_period     <= '0;
            r_cont       <= 1'b0;
            r_ito        <= 1'b0;
            r_ret_run    <= 1'b0;
            r_poll_cnt   <= '0;
            r_running    <= 1'b0;
            r_tick_cnt   <= '0;
            r_snap_l     <= '0;
            r_snap_value <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            if (w_take_start) r_start_pend <= 1'b0;
            if (cfg_start && !cfg_stop) begin
                r_start_pend <= 1'b1;
                r_p_period   <= cfg_period;
                r_p_cont     <= cfg_continuous;
                r_p_ito      <= cfg_irq_en;
            end
            // A stop always cancels any start still waiting for dispatch.
            if (cfg_stop) begin
                r_stop_pend  <= 1'b1;
                r_start_pend <= 1'b0;
            end else if (w_take_stop) begin
                r_stop_pend <= 1'b0;
            end
            if (snap_req)         r_snap_pend <= 1'b1;
            else if (w_take_snap) r_snap_pend <= 1'b0;
            if (w_take_start) begin
                r_period <= r_p_period;
                r_cont   <= r_p_cont;
                r_ito    <= r_p_ito;
            end
            if (w_take_snap) r_ret_run <= (r_state == S_RUN);
            if (r_state == S_RUN && !w_poll_due) r_poll_cnt <= r_poll_cnt + 16'd1;
            else                                 r_poll_cnt <= '0;
            if (w_done) begin
                if (r_state == S_CFG_CTL)
                    r_running <= 1'b1;
                else if (r_state == S_CFG_STOP || r_state == S_HALT)
                    r_running <= 1'b0;
                else if (r_state == S_CLR && !r_cont)
                    r_running <= 1'b0;
                else if (r_state == S_POLL_WAIT && w_expired)
                    r_running <= 1'b0;
            end
            if (tick) r_tick_cnt <= r_tick_cnt + 16'd1;
            if (r_state == S_SNAP_RDL && w_done) r_snap_l <= w_rdata;
            r_snap_valid <= 1'b0;
            if (r_state == S_SNAP_RDH && w_done) begin
                r_snap_value <= {w_rdata, r_snap_l};
                r_snap_valid <= 1'b1;
            end
        end
    end

    assign running    = r_running;
    assign tick_count = r_tick_cnt;
    assign snap_value = r_snap_value;
    assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb_timer_ctrl_master: behavioural timer slave plus a bus-access
// scoreboard; status polls are counted separately from other accesses.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_continuous = 1'b0;
    logic        cfg_irq_en = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        snap_req = 1'b0;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_irq;
    logic        busy;
    logic        running;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;

    int errors = 0;
    int checks = 0;
    int n_status_rd = 0;
    int cyc_no = 0;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no++;

    timer_ctrl_master #(
        .POLL_INTERVAL(16),
        .RD_LATENCY(1)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_start     (cfg_start),
        .cfg_period    (cfg_period),
        .cfg_continuous(cfg_continuous),
        .cfg_irq_en    (cfg_irq_en),
        .cfg_stop      (cfg_stop),
        .snap_req      (snap_req),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .av_irq        (av_irq),
        .busy          (busy),
        .running       (running),
        .tick          (tick),
        .tick_count    (tick_count),
        .snap_value    (snap_value),
        .snap_valid    (snap_valid)
    );

    // Behavioural interval timer: counts period..0, registered readdata.
    logic        s_to = 1'b0;
    logic        s_run = 1'b0;
    logic        s_cont = 1'b0;
    logic        s_ito = 1'b0;
    logic        force_snap = 1'b0;
    logic [31:0] s_period = '0;
    logic [31:0] s_cnt = '0;
    logic [31:0] s_snap = '0;
    logic [15:0] s_rd = '0;

    assign av_readdata = s_rd;
    assign av_irq      = s_to & s_ito;

    always @(posedge clk) begin
        if (s_run) begin
            if (s_cnt == 0) begin
                s_to <= 1'b1;
                if (s_cont) s_cnt <= s_period;
                else        s_run <= 1'b0;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
        if (av_chipselect && !av_write_n) begin
            case (av_address)
                3'd0: s_to <= 1'b0;
                3'd1: begin
                    s_ito  <= av_writedata[0];
                    s_cont <= av_writedata[1];
                    if (av_writedata[3]) s_run <= 1'b0;
                    if (av_writedata[2]) begin
                        s_run <= 1'b1;
                        s_cnt <= s_period;
                    end
                end
                3'd2: s_period[15:0]  <= av_writedata;
                3'd3: s_period[31:16] <= av_writedata;
                3'd4, 3'd5: s_snap <= force_snap ? 32'h1234_5678 : s_cnt;
                default: ;
            endcase
        end
        if (av_chipselect && av_write_n) begin
            case (av_address)
                3'd0:    s_rd <= {14'd0, s_run, s_to};
                3'd4:    s_rd <= s_snap[15:0];
                3'd5:    s_rd <= s_snap[31:16];
                default: s_rd <= 16'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        acc_t e;
        if (reset_n && av_chipselect) begin
            if (av_write_n && av_address == 3'd0) begin
                n_status_rd++;
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_access: got we=%0b addr=%0d data=%h, required no access",
                             !av_write_n, av_address, av_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.we !== !av_write_n || e.addr !== av_address ||
                        (e.we && e.data !== av_writedata)) begin
                        errors++;
                        $display("FAIL bus_access: got we=%0b addr=%0d data=%h, required we=%0b addr=%0d data=%h",
                                 !av_write_n, av_address, av_writedata, e.we, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic push(input logic we, input logic [2:0] a, input logic [15:0] d);
        acc_t e;
        e.we   = we;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_cfg(input logic [31:0] p, input logic [15:0] ctl);
        push(1'b1, 3'd1, 16'h0008);
        push(1'b1, 3'd2, p[15:0]);
        push(1'b1, 3'd3, p[31:16]);
        push(1'b1, 3'd1, ctl);
    endtask

    task automatic start_cmd(input logic [31:0] p, input logic c, input logic i);
        @(posedge clk);
        #1;
        cfg_period     = p;
        cfg_continuous = c;
        cfg_irq_en     = i;
        cfg_start      = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic halt_timer(output bit ok);
        push(1'b1, 3'd1, 16'h0008);
        @(posedge clk);
        #1;
        cfg_stop = 1'b1;
        @(posedge clk);
        #1;
        cfg_stop = 1'b0;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !running && exp_q.size() == 0) ok = 1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b0, 1'b1, 3'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h, required 0 1 0 0000",
                     av_chipselect, av_write_n, av_address, av_writedata);
        end
        checks++;
        if ({busy, running, tick, snap_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {busy, running, tick, snap_valid});
        end
        checks++;
        if (tick_count !== 16'd0 || snap_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got tc=%h sv=%h, required 0", tick_count, snap_value);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_config();
        int  nb;
        bit  ok;
        push_cfg(32'h0001_E847, 16'h0006);
        start_cmd(32'h0001_E847, 1'b1, 1'b0);
        nb = 0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (running) ok = 1;
            else if (busy) nb++;
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL cfg_running: got %b, required 1", running);
        end
        checks++;
        if (nb != 8) begin
            errors++;
            $display("FAIL cfg_cycles: got %0d, required 8", nb);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL cfg_writes: got %0d pending, required 0", exp_q.size());
        end
        halt_timer(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cfg_halt: got busy=%b running=%b pending=%0d, required 0 0 0",
                     busy, running, exp_q.size());
        end
    endtask

    task automatic test_continuous();
        int  t[3];
        int  n;
        int  base;
        bit  ok;
        push_cfg(32'd200, 16'h0006);
        for (int i = 0; i < 3; i++) push(1'b1, 3'd0, 16'h0000);
        base = int'(tick_count);
        start_cmd(32'd200, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 1500 && n < 3; i++) begin
            @(negedge clk);
            if (tick) begin
                t[n] = cyc_no;
                n++;
            end
        end
        @(negedge clk);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL cont_ticks: got %0d ticks, required 3", n);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (n == 3 && (t[i] - t[i-1] < 170 || t[i] - t[i-1] > 235)) begin
                errors++;
                $display("FAIL cont_interval%0d: got %0d cycles, required 170..235",
                         i, t[i] - t[i-1]);
            end
        end
        checks++;
        if (int'(tick_count) - base != 3) begin
            errors++;
            $display("FAIL cont_tick_count: got %0d, required %0d", tick_count, base + 3);
        end
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL cont_running: got %b, required 1", running);
        end
        halt_timer(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cont_halt: got busy=%b running=%b pending=%0d, required 0 0 0",
                     busy, running, exp_q.size());
        end
    endtask

    task automatic test_oneshot();
        int  base;
        int  rd0;
        bit  seen;
        push_cfg(32'd100, 16'h0004);
        push(1'b1, 3'd0, 16'h0000);
        base = int'(tick_count);
        start_cmd(32'd100, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (tick) seen = 1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || running !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_end: got tick=%b running=%b busy=%b, required 1 0 0",
                     seen, running, busy);
        end
        rd0 = n_status_rd;
        repeat (300) @(negedge clk);
        checks++;
        if (n_status_rd != rd0) begin
            errors++;
            $display("FAIL oneshot_polls: got %0d extra status reads, required 0", n_status_rd - rd0);
        end
        checks++;
        if (int'(tick_count) - base != 1) begin
            errors++;
            $display("FAIL oneshot_tick_count: got %0d, required %0d", tick_count, base + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL oneshot_writes: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_snapshot();
        int          np;
        logic [31:0] v;
        bit          ok;
        push_cfg(32'd5000, 16'h0006);
        start_cmd(32'd5000, 1'b1, 1'b0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (running) ok = 1;
        end
        force_snap = 1'b1;
        push(1'b1, 3'd4, 16'h0000);
        push(1'b0, 3'd4, 16'h0000);
        push(1'b0, 3'd5, 16'h0000);
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        np = 0;
        v  = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (snap_valid) begin
                np++;
                v = snap_value;
            end
        end
        checks++;
        if (np != 1) begin
            errors++;
            $display("FAIL snap_pulses: got %0d, required 1", np);
        end
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL snap_value: got %h, required 12345678", v);
        end
        checks++;
        if (running !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL snap_return: got running=%b busy=%b pending=%0d, required 1 0 0",
                     running, busy, exp_q.size());
        end
        halt_timer(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL snap_halt: got busy=%b running=%b pending=%0d, required 0 0 0",
                     busy, running, exp_q.size());
        end
    endtask

    task automatic test_collision();
        bit ok;
        push_cfg(32'd300, 16'h0006);
        start_cmd(32'd300, 1'b1, 1'b0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (av_chipselect && !av_write_n && av_address == 3'd1) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coll_first_write: got none, required control write");
        end
        push(1'b1, 3'd1, 16'h0008);
        @(posedge clk);
        #1;
        cfg_period     = 32'h0000_0777;
        cfg_continuous = 1'b0;
        cfg_stop       = 1'b1;
        cfg_start      = 1'b1;
        @(posedge clk);
        #1;
        cfg_stop  = 1'b0;
        cfg_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !running && exp_q.size() == 0) ok = 1;
        end
        repeat (100) @(negedge clk);
        checks++;
        if (!ok || running !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_halt: got done=%b running=%b busy=%b, required 1 0 0",
                     ok, running, busy);
        end
        checks++;
        if (s_period !== 32'd300) begin
            errors++;
            $display("FAIL coll_discard: got slave period %h, required 0000012c", s_period);
        end
    endtask

    task automatic test_reset_mid_snap();
        bit ok;
        bit seen;
        force_snap = 1'b1;
        push(1'b1, 3'd4, 16'h0000);
        push(1'b0, 3'd4, 16'h0000);
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (av_chipselect && av_write_n && av_address == 3'd4) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_snap_rdl: got none, required read of addr 4");
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({av_chipselect, av_write_n, busy, running} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_snap_outputs: got cs=%b wn=%b busy=%b run=%b, required 0 1 0 0",
                     av_chipselect, av_write_n, busy, running);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (snap_valid || av_chipselect) seen = 1;
            if (i == 3) reset_n = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_snap_quiet: got snap_valid or access after reset, required none");
        end
        checks++;
        if (snap_value !== 32'd0 || tick_count !== 16'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_snap_values: got sv=%h tc=%h pending=%0d, required 0 0 0",
                     snap_value, tick_count, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_continuous();
        test_oneshot();
        test_snapshot();
        test_collision();
        test_reset_mid_snap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
